lif_chain_sequencer: RTL and testbench
======================================

Name: lif_chain_sequencer

Overview:
Time-multiplexed controller that runs an NUM_STAGES-deep chain of leaky integrate-and-fire neuron stages on one shared neuron-update engine. It holds every stage's membrane potential locally and sweeps all stages once per timestep, presenting each stage's operands to the engine over a valid/ready handshake. Stages are swept in descending order, so each timestep is bit-identical to one clock of a fully parallel registered chain in which stage k is driven by stage k-1's previous V_mem. It sits between the tile I/O (ui_in / uo_out) and a single neuron engine instance.

Parameters:
NUM_STAGES, 7, number of chained neuron stages (2..16)
WIDTH, 8, membrane / synaptic current width in bits
SW (localparam), max(1, ceil(log2(NUM_STAGES))), stage index width

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  request one timestep sweep; sampled only in IDLE
clear  in  1  zero all stored membrane potentials; honoured only in IDLE
ext_in  in  WIDTH  external synaptic current for stage 0; latched when start is accepted
eng_valid  out  1  operands valid for the engine
eng_ready  in  1  engine accepts the operands; eng_v_new is valid in the same cycle
eng_stage  out  SW  index of the stage being updated
eng_i_syn  out  WIDTH  synaptic current for the stage
eng_v_prev  out  WIDTH  stored V_mem of the stage
eng_v_new  in  WIDTH  updated V_mem returned by the engine
busy  out  1  high whenever state is not IDLE
done  out  1  one-cycle pulse at the end of a sweep
result  out  WIDTH  V_mem of stage NUM_STAGES-1, registered
overrun  out  1  sticky flag: start was asserted while busy

Behaviour:
- Reset (asynchronous, takes effect immediately, no clock edge needed): state IDLE, all V[i]=0, latched input=0, stage counter=0, eng_valid=0, busy=0, done=0, result=0, overrun=0. Reset in mid-sweep abandons the sweep. eng_valid falls combinationally with rst.
- FSM states are IDLE, ISSUE and DONE.
- IDLE:
  - clear=1 zeroes all V[i] on the next edge.
  - start=1 latches ext_in, sets stage=NUM_STAGES-1 and goes to ISSUE.
  - If start and clear are both asserted in the same cycle, clear is applied first, then the sweep starts from zeroed state.
- ISSUE:
  - eng_valid=1, eng_stage=stage, eng_v_prev=V[stage].
  - eng_i_syn = latched ext_in when stage==0, otherwise V[stage-1]. V[stage-1] has not yet been updated in this sweep.
  - Transfer occurs on an edge where eng_valid and eng_ready are both 1. On transfer, V[stage] <= eng_v_new.
  - If stage==NUM_STAGES-1 at transfer, result <= eng_v_new.
  - If stage==0 at transfer, go to DONE; otherwise stage <= stage-1 and stay in ISSUE. eng_valid stays high, so back-to-back transfers run at one stage per cycle.
  - While eng_ready=0, eng_stage, eng_i_syn and eng_v_prev are held stable and no state changes.
  - clear is ignored.
- DONE: done=1 for exactly one cycle, then return to IDLE. eng_valid=0 in DONE.
- busy=1 in ISSUE and DONE.
- start asserted while busy: the start is ignored and overrun is set to 1. overrun stays set until rst. The ongoing sweep is unaffected.
- Latency with eng_ready tied high: start is sampled at edge 0, engine transfers occur at edges 1..NUM_STAGES, and done is high during the cycle after edge NUM_STAGES. That is a total of NUM_STAGES+1 cycles start-to-done; a new start is accepted the cycle after done.
- Arithmetic: none inside the block. Values are stored exactly as the engine returns them, with no saturation or wrap applied here.

Test Plan:
1. Assert rst for 2 cycles, then release -> all outputs 0, busy=0, overrun=0. Drive rst high asynchronously mid-ISSUE -> eng_valid drops within the same cycle; the next sweep with stub v_new=i_syn+1 and ext_in=10 gives result=1.
2. Engine stub v_new=i_syn+1, eng_ready=1, NUM_STAGES=7; run 7 sweeps with ext_in=10 -> result sequence 1,2,3,4,5,6,17. eng_stage order per sweep is 6,5,4,3,2,1,0. done occurs 8 cycles after each start.
3. Backpressure: hold eng_ready=0 for 3 cycles while eng_stage=4 -> eng_stage, eng_i_syn and eng_v_prev stay stable throughout. done is delayed by exactly 3 cycles. Final V values are identical to scenario 2.
4. Pulse start during ISSUE and again during DONE -> overrun=1 and remains 1. Exactly one done pulse per accepted start, and stored values are unchanged versus the reference sweep.
5. After 3 sweeps, pulse clear in IDLE, then start with ext_in=10 -> result=1 and V[0]=11. A clear pulsed during ISSUE -> no effect on V.
6. start and clear asserted together in IDLE with nonzero stored V -> the sweep behaves as if starting from all-zero state (result=1).

Source files
------------

// File: rtl/lif_chain_sequencer.sv
// lif_chain_sequencer
// Time-multiplexed controller for a NUM_STAGES-deep chain of leaky
// integrate-and-fire stages sharing one neuron-update engine. All membrane
// potentials live here. Each timestep sweeps the stages from the last down to
// stage 0. A stage therefore always reads its predecessor's value from the
// previous timestep, which matches one clock of a fully parallel registered
// chain.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   start        request one sweep (accepted only when idle)
//   clear        zero all membrane potentials (honoured only when idle)
//   ext_in       synaptic current for stage 0, latched when start is accepted
//   eng_valid    operands below are valid for the engine
//   eng_ready    engine accepts the operands; eng_v_new is valid in the same cycle
//   eng_stage    index of the stage being updated
//   eng_i_syn    synaptic current for that stage
//   eng_v_prev   stored membrane potential of that stage
//   eng_v_new    updated membrane potential returned by the engine
//   busy         sweep in progress (ISSUE or DONE)
//   done         one-cycle pulse at the end of a sweep
//   result       last stage's membrane potential, registered
//   overrun      sticky: start was seen while busy
module lif_chain_sequencer #(
  parameter int unsigned NUM_STAGES = 7,
  parameter int unsigned WIDTH      = 8,
  localparam int unsigned SW        = (NUM_STAGES <= 2) ? 1 : $clog2(NUM_STAGES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             clear,
  input  logic [WIDTH-1:0] ext_in,
  output logic             eng_valid,
  input  logic             eng_ready,
  output logic [SW-1:0]    eng_stage,
  output logic [WIDTH-1:0] eng_i_syn,
  output logic [WIDTH-1:0] eng_v_prev,
  input  logic [WIDTH-1:0] eng_v_new,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             overrun
);

  localparam logic [SW-1:0] LastStage = SW'(NUM_STAGES - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] v_q [NUM_STAGES];
  logic [WIDTH-1:0] ext_q;
  logic [SW-1:0]    stage_q;
  logic [SW-1:0]    prev_stage;
  logic [WIDTH-1:0] result_q;
  logic             overrun_q;
  logic             xfer;

  assign xfer       = (state_q == StIssue) && eng_ready;
  assign prev_stage = stage_q - SW'(1);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StIssue;
      StIssue: if (eng_ready && (stage_q == '0)) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs; eng_valid decodes the state register so it drops with rst.
  always_comb begin
    eng_valid  = (state_q == StIssue);
    busy       = (state_q != StIdle);
    done       = (state_q == StDone);
    eng_stage  = stage_q;
    eng_v_prev = v_q[stage_q];
    // prev_stage wraps when stage_q is 0; that read is discarded by the mux.
    eng_i_syn  = (stage_q == '0) ? ext_q : v_q[prev_stage];
    result     = result_q;
    overrun    = overrun_q;
  end

  // Datapath: membrane store, latched input, stage counter, flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_STAGES; i++) v_q[i] <= '0;
      ext_q     <= '0;
      stage_q   <= '0;
      result_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (state_q == StIdle) begin
        // Clear and start together: the sweep then reads zeroed potentials.
        if (clear) begin
          for (int i = 0; i < NUM_STAGES; i++) v_q[i] <= '0;
        end
        if (start) begin
          ext_q   <= ext_in;
          stage_q <= LastStage;
        end
      end
      if (xfer) begin
        v_q[stage_q] <= eng_v_new;
        if (stage_q == LastStage) result_q <= eng_v_new;
        if (stage_q != '0) stage_q <= prev_stage;
      end
      if (start && (state_q != StIdle)) overrun_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lif_chain_sequencer.sv
// Directed, table-driven bench for lif_chain_sequencer. An engine stub returns
// i_syn + 1. A reference array of membrane potentials predicts the operands
// of every transfer, and each table row carries a hand-computed result and
// start-to-done latency.
module tb_lif_chain_sequencer;

  localparam int NS = 7;
  localparam int W  = 8;
  localparam int SWB = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic           clear = 1'b0;
  logic [W-1:0]   ext_in = '0;
  logic           eng_valid;
  logic           eng_ready = 1'b1;
  logic [SWB-1:0] eng_stage;
  logic [W-1:0]   eng_i_syn;
  logic [W-1:0]   eng_v_prev;
  logic [W-1:0]   eng_v_new;
  logic           busy;
  logic           done;
  logic [W-1:0]   result;
  logic           overrun;

  lif_chain_sequencer #(.NUM_STAGES(NS), .WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .clear      (clear),
    .ext_in     (ext_in),
    .eng_valid  (eng_valid),
    .eng_ready  (eng_ready),
    .eng_stage  (eng_stage),
    .eng_i_syn  (eng_i_syn),
    .eng_v_prev (eng_v_prev),
    .eng_v_new  (eng_v_new),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  // Engine stub
  assign eng_v_new = eng_i_syn + 8'd1;

  typedef struct {
    logic [W-1:0] ext;
    bit           clr_with_start;
    bit           pre_clear;
    int           stall_stage;
    int           stall_n;
    bit           mid_start;
    bit           mid_clear;
    logic [W-1:0] exp_result;
    int           exp_cycles;
    bit           exp_overrun;
  } row_t;

  row_t         rows [12];
  logic [W-1:0] mv [NS];
  int           n_checks = 0;
  int           n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic zero_model();
    for (int i = 0; i < NS; i++) mv[i] = '0;
  endtask

  // Runs one sweep starting at a negedge; returns at a negedge with the DUT idle.
  task automatic run_row(input row_t r);
    int           cyc;
    int           exp_stage;
    int           stalls_left;
    bit           seen_done;
    logic [W-1:0] exp_isyn;
    if (r.pre_clear) begin
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      zero_model();
      @(negedge clk);
    end
    start  = 1'b1;
    clear  = r.clr_with_start;
    ext_in = r.ext;
    if (r.clr_with_start) zero_model();
    @(negedge clk);
    cyc         = 1;
    exp_stage   = NS - 1;
    stalls_left = r.stall_n;
    seen_done   = 1'b0;
    while (!seen_done && cyc < 40) begin
      start     = 1'b0;
      clear     = 1'b0;
      eng_ready = 1'b1;
      if (r.mid_clear && cyc == 2) clear = 1'b1;
      if (r.mid_start && cyc == 3) start = 1'b1;
      if (done) begin
        seen_done = 1'b1;
        check("latency", cyc, r.exp_cycles);
        check("busy_in_done", busy, 1);
        check("valid_in_done", eng_valid, 0);
        check("result", result, r.exp_result);
        if (r.mid_start) start = 1'b1;
      end else if (eng_valid) begin
        exp_isyn = (exp_stage == 0) ? r.ext : mv[exp_stage-1];
        check("eng_stage", eng_stage, exp_stage);
        check("eng_i_syn", eng_i_syn, exp_isyn);
        check("eng_v_prev", eng_v_prev, mv[exp_stage]);
        if (exp_stage == r.stall_stage && stalls_left > 0) begin
          eng_ready = 1'b0;
          stalls_left--;
        end else begin
          mv[exp_stage] = exp_isyn + 8'd1;
          exp_stage--;
        end
      end
      @(negedge clk);
      cyc++;
    end
    if (!seen_done) check("done_timeout", 0, 1);
    start     = 1'b0;
    clear     = 1'b0;
    eng_ready = 1'b1;
    check("done_one_cycle", done, 0);
    check("busy_after", busy, 0);
    check("overrun", overrun, r.exp_overrun);
  endtask

  initial begin
    //          ext  cws pre stl  n  ms mc  res cyc ovr
    rows[0]  = '{8'd10, 1, 0, -1, 0, 0, 0, 8'd1,  8,  0};  // start+clear over nonzero V
    rows[1]  = '{8'd10, 0, 0, -1, 0, 0, 0, 8'd2,  8,  0};
    rows[2]  = '{8'd10, 0, 0, -1, 0, 0, 0, 8'd3,  8,  0};
    rows[3]  = '{8'd10, 0, 0, -1, 0, 0, 0, 8'd4,  8,  0};
    rows[4]  = '{8'd10, 0, 0, -1, 0, 0, 0, 8'd5,  8,  0};
    rows[5]  = '{8'd10, 0, 0, -1, 0, 0, 0, 8'd6,  8,  0};
    rows[6]  = '{8'd10, 0, 0, -1, 0, 0, 0, 8'd17, 8,  0};
    rows[7]  = '{8'd10, 1, 0,  4, 3, 0, 0, 8'd1,  11, 0};  // backpressure at stage 4
    rows[8]  = '{8'd10, 0, 0, -1, 0, 1, 0, 8'd2,  8,  1};  // start in ISSUE and DONE
    rows[9]  = '{8'd10, 0, 0, -1, 0, 0, 1, 8'd3,  8,  1};  // clear during ISSUE ignored
    rows[10] = '{8'd10, 0, 1, -1, 0, 0, 0, 8'd1,  8,  1};  // clear in IDLE first
    rows[11] = '{8'd10, 0, 0, -1, 0, 0, 0, 8'd2,  8,  1};  // V[0]=11 seen as v_prev

    // Reset state
    zero_model();
    repeat (2) @(negedge clk);
    check("rst_valid", eng_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_overrun", overrun, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", busy, 0);

    // Asynchronous reset in mid-sweep
    start  = 1'b1;
    ext_in = 8'd10;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("pre_rst_valid", eng_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", eng_valid, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_result", result, 0);
    @(negedge clk);
    rst = 1'b0;
    zero_model();
    @(negedge clk);
    run_row('{8'd10, 0, 0, -1, 0, 0, 0, 8'd1, 8, 0});

    for (int k = 0; k < 12; k++) run_row(rows[k]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
